// File: rtl/exp_adjust_unit.sv
// ---------------------------------------------------------------------------
// exp_adjust_unit
//
// Purpose:
//   Moves a floating-point exponent field up or down by a requested number of
//   unit steps. The result saturates: increments stop at the all-ones
//   (infinity) encoding and raise ovf. Decrements stop at zero and raise unf
//   when a step below zero is attempted. The exponent never wraps.
//
// Build option:
//   EXP_ADJ_FAST_EN - when defined, the saturated result and the flags are
//                     computed in one step when a request is accepted, and
//                     the unit goes straight to DONE. When undefined (the
//                     default), one step is applied per clock in RUN.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   request present
//   in_ready   out  unit can accept a request (high only in IDLE)
//   op_dec     in   1 = decrement, 0 = increment
//   exp_in     in   starting exponent            [EXP_W]
//   amount     in   number of unit steps          [AMT_W]
//   out_valid  out  result present (high only in DONE)
//   out_ready  in   consumer accepts the result
//   exp_out    out  adjusted exponent             [EXP_W]
//   ovf        out  increment reached or hit the all-ones encoding
//   unf        out  decrement attempted below zero
//   busy       out  state is not IDLE
//   state_o    out  debug view of the FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake:
//   Both interfaces use valid/ready. A transfer happens on a rising edge
//   where valid and ready are both high. The request side is ready only in
//   IDLE, so in_valid is ignored while a request is being processed.
//   Once out_valid rises, it stays high and exp_out/ovf/unf stay constant
//   until the transfer edge.
// ---------------------------------------------------------------------------
module exp_adjust_unit #(
  parameter int EXP_W = 5,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_dec,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [AMT_W-1:0] amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_out,
  output logic             ovf,
  output logic             unf,
  output logic             busy,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [EXP_W-1:0] EXP_MAX    = '1;
  localparam logic [EXP_W-1:0] EXP_MAX_M1 = EXP_MAX - 1'b1;
  localparam logic [EXP_W-1:0] EXP_ZERO   = '0;
  localparam logic [AMT_W-1:0] AMT_ZERO   = '0;
  localparam logic [AMT_W-1:0] AMT_ONE    = {{(AMT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [EXP_W-1:0] exp_q,   exp_d;
  logic [AMT_W-1:0] cnt_q,   cnt_d;
  logic             dec_q,   dec_d;
  logic             ovf_q,   ovf_d;
  logic             unf_q,   unf_d;

  logic             accept;
  logic             deliver;

  assign accept  = in_valid  && (state_q == S_IDLE);
  assign deliver = out_ready && (state_q == S_DONE);

`ifdef EXP_ADJ_FAST_EN
  // Closed-form saturating result. The operands are widened to hold both
  // fields plus a carry, so the comparison against the limit is exact.
  localparam int EXT_W = ((EXP_W > AMT_W) ? EXP_W : AMT_W) + 1;

  logic [EXT_W-1:0] ext_exp;
  logic [EXT_W-1:0] ext_amt;
  logic [EXT_W-1:0] ext_sum;
  logic [EXT_W-1:0] ext_max;
  logic [EXT_W-1:0] ext_dif;
  logic [EXP_W-1:0] fast_exp;
  logic             fast_ovf;
  logic             fast_unf;

  assign ext_exp = EXT_W'(exp_in);
  assign ext_amt = EXT_W'(amount);
  assign ext_sum = ext_exp + ext_amt;
  assign ext_max = EXT_W'(EXP_MAX);
  assign ext_dif = ext_exp - ext_amt;

  always_comb begin
    fast_exp = exp_in;
    fast_ovf = 1'b0;
    fast_unf = 1'b0;
    if (amount != AMT_ZERO) begin
      if (op_dec) begin
        // Underflow only when a step below zero would be needed.
        if (ext_amt > ext_exp) begin
          fast_exp = EXP_ZERO;
          fast_unf = 1'b1;
        end else begin
          fast_exp = ext_dif[EXP_W-1:0];
        end
      end else begin
        // Reaching all-ones is itself an overflow.
        if (ext_sum >= ext_max) begin
          fast_exp = EXP_MAX;
          fast_ovf = 1'b1;
        end else begin
          fast_exp = ext_sum[EXP_W-1:0];
        end
      end
    end
  end
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          dec_d = op_dec;
`ifdef EXP_ADJ_FAST_EN
          exp_d   = fast_exp;
          ovf_d   = fast_ovf;
          unf_d   = fast_unf;
          cnt_d   = AMT_ZERO;
          state_d = S_DONE;
`else
          exp_d   = exp_in;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          cnt_d   = amount;
          state_d = (amount == AMT_ZERO) ? S_DONE : S_RUN;
`endif
        end
      end

      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (!dec_q) begin
          if (exp_q == EXP_MAX) begin
            // A step above all-ones: hold the value and flag it.
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            exp_d = exp_q + 1'b1;
            if (exp_q == EXP_MAX_M1) begin
              // The result becomes all-ones; any remaining steps are dropped.
              ovf_d   = 1'b1;
              state_d = S_DONE;
            end else if (cnt_q == AMT_ONE) begin
              state_d = S_DONE;
            end
          end
        end else begin
          if (exp_q == EXP_ZERO) begin
            // A step below zero: hold zero and flag it.
            unf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            // Reaching zero exactly is a valid result and sets no flag.
            exp_d = exp_q - 1'b1;
            if (cnt_q == AMT_ONE) begin
              state_d = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        if (deliver) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign exp_out   = exp_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_exp_adjust_unit.sv
module tb_exp_adjust_unit;

  localparam int EXP_W = 5;
  localparam int AMT_W = 4;
  localparam int MAXV  = (1 << EXP_W) - 1;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             op_dec;
  logic [EXP_W-1:0] exp_in;
  logic [AMT_W-1:0] amount;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] exp_out;
  logic             ovf;
  logic             unf;
  logic             busy;
  logic [1:0]       state_o;

  always #5 clk = ~clk;

  exp_adjust_unit #(.EXP_W(EXP_W), .AMT_W(AMT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_dec   (op_dec),
    .exp_in   (exp_in),
    .amount   (amount),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .exp_out  (exp_out),
    .ovf      (ovf),
    .unf      (unf),
    .busy     (busy),
    .state_o  (state_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned e;
    bit          dec;
    int unsigned amt;
    int unsigned exp_o;
    bit          ovf;
    bit          unf;
    int unsigned lat;
  } vec_t;

  // Result expected for each accepted request, pushed by the model.
  logic [EXP_W+2+8-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Uses saturating integer arithmetic. The latency is the number of unit
  // steps taken, counting the final attempt that hits a limit.
  function automatic vec_t model(int unsigned e, bit dec, int unsigned amt);
    vec_t r;
    r.e = e; r.dec = dec; r.amt = amt;
    r.ovf = 1'b0; r.unf = 1'b0;
    if (amt == 0) begin
      r.exp_o = e; r.lat = 0;
    end else if (!dec) begin
      if (e + amt >= MAXV) begin
        r.exp_o = MAXV; r.ovf = 1'b1;
        r.lat = (e == MAXV) ? 1 : (MAXV - e);
      end else begin
        r.exp_o = e + amt; r.lat = amt;
      end
    end else begin
      if (amt > e) begin
        r.exp_o = 0; r.unf = 1'b1; r.lat = e + 1;
      end else begin
        r.exp_o = e - amt; r.lat = amt;
      end
    end
`ifdef EXP_ADJ_FAST_EN
    r.lat = 0;
`endif
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_in_ready(output bit ok);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    ok = in_ready;
    if (!ok) check("in_ready_timeout", 0, 1);
  endtask

  // Drives one request and waits for the result. Returns the number of
  // edges after the accept edge before out_valid was first seen.
  task automatic send(input int unsigned e, input bit dec, input int unsigned amt,
                      output int lat, output bit ok);
    bit rdy;
    wait_in_ready(rdy);
    ok = 1'b0;
    lat = 0;
    if (rdy) begin
      in_valid = 1'b1;
      exp_in   = EXP_W'(e);
      op_dec   = dec;
      amount   = AMT_W'(amt);
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_in   = $urandom_range(0, MAXV);
      amount   = $urandom_range(0, 15);
      while (!out_valid && lat < 200) begin
        @(posedge clk); #1; lat++;
      end
      ok = out_valid;
      if (!ok) check("out_valid_timeout", 0, 1);
    end
  endtask

  task automatic release_result(input int delay);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Pops the expected result from the queue and compares it with the outputs.
  task automatic score(input string tag, input int lat, input bit ok);
    logic [EXP_W+2+8-1:0] x;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 0, 1);
    end else begin
      x = exp_q.pop_front();
      if (ok) begin
        check({tag, "_exp_out"}, int'(exp_out), int'(x[EXP_W+9:10]));
        check({tag, "_ovf"},     int'(ovf),     int'(x[9]));
        check({tag, "_unf"},     int'(unf),     int'(x[8]));
        check({tag, "_latency"}, lat,           int'(x[7:0]));
      end
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v, input int delay);
    int lat;
    bit ok;
    exp_q.push_back({EXP_W'(v.exp_o), v.ovf, v.unf, 8'(v.lat)});
    send(v.e, v.dec, v.amt, lat, ok);
    score(tag, lat, ok);
    if (ok) begin
      release_result(delay);
      check({tag, "_out_valid_after_release"}, int'(out_valid), 0);
      check({tag, "_in_ready_after_release"},  int'(in_ready),  1);
    end
  endtask

  // ---------------- test ----------------
  vec_t tbl[6];

  initial begin
    int lat;
    bit ok;
    bit seen;
    vec_t v;

    reset = 1'b1; in_valid = 1'b0; op_dec = 1'b0;
    exp_in = '0; amount = '0; out_ready = 1'b0;

    // Directed vectors: {exp_in, dec, amount, exp_out, ovf, unf, latency}
    tbl[0] = '{15, 1'b0, 3, 18, 1'b0, 1'b0, 3};
    tbl[1] = '{29, 1'b0, 5, 31, 1'b1, 1'b0, 2};
    tbl[2] = '{31, 1'b0, 1, 31, 1'b1, 1'b0, 1};
    tbl[3] = '{ 2, 1'b1, 4,  0, 1'b0, 1'b1, 3};
    tbl[4] = '{ 2, 1'b1, 2,  0, 1'b0, 1'b0, 2};
    tbl[5] = '{ 7, 1'b0, 0,  7, 1'b0, 1'b0, 0};
`ifdef EXP_ADJ_FAST_EN
    for (int i = 0; i < 6; i++) tbl[i].lat = 0;
`endif

    // Reset state, sampled while reset is still asserted
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_in_ready",  int'(in_ready),  1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy",      int'(busy),      0);
    check("rst_exp_out",   int'(exp_out),   0);
    check("rst_ovf",       int'(ovf),       0);
    check("rst_unf",       int'(unf),       0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i], 0);
    end

    // Result held while out_ready stays low; a second request is refused
    v = model(15, 1'b0, 3);
    exp_q.push_back({EXP_W'(v.exp_o), v.ovf, v.unf, 8'(v.lat)});
    send(15, 1'b0, 3, lat, ok);
    score("stall", lat, ok);
    if (ok) begin
      in_valid = 1'b1; exp_in = 5'd3; op_dec = 1'b1; amount = 4'd1;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        check("stall_out_valid", int'(out_valid), 1);
        check("stall_in_ready",  int'(in_ready),  0);
        check("stall_exp_out",   int'(exp_out),   18);
        check("stall_ovf",       int'(ovf),       0);
        check("stall_unf",       int'(unf),       0);
      end
      in_valid = 1'b0;
      release_result(0);
      check("stall_idle_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      check("stall_no_second_accept", int'(busy), 0);
    end

    // Reset during processing drops the pending result
    in_valid = 1'b1; exp_in = 5'd10; op_dec = 1'b0; amount = 4'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_in_ready",  int'(in_ready),  1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy",      int'(busy),      0);
    check("midrst_exp_out",   int'(exp_out),   0);
    check("midrst_ovf",       int'(ovf),       0);
    check("midrst_unf",       int'(unf),       0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_out_valid", int'(seen), 0);

    // Random requests against the model
    for (int i = 0; i < 60; i++) begin
      v = model($urandom_range(0, MAXV), 1'($urandom_range(0, 1)), $urandom_range(0, 15));
      run_vec($sformatf("rnd%0d", i), v, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exp_adjust_unit.md
EXP_ADJUST_UNIT -- requirements
Module: exp_adjust_unit

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width (half precision).
REQ-002 SHALL have parameter AMT_W, default 4, width of the adjust-amount field.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  unit can accept a request.
REQ-008 SHALL have port op_dec  input  1  1 = decrement, 0 = increment.
REQ-009 SHALL have port exp_in  input  EXP_W  starting exponent.
REQ-010 SHALL have port amount  input  AMT_W  number of unit steps requested.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port exp_out  output  EXP_W  adjusted exponent.
REQ-014 SHALL have port ovf  output  1  result is all-ones (infinity encoding) from an increment.
REQ-015 SHALL have port unf  output  1  decrement attempted below zero.
REQ-016 SHALL have port busy  output  1  state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 SHALL drive in_ready high only in IDLE; a request is accepted on an edge where in_valid and in_ready are both high.
REQ-019 SHALL, on accept, register exp_in, op_dec and amount, and clear ovf/unf.
REQ-020 SHALL, on accept, go to DONE if amount is 0 (exp_out = exp_in) and to RUN otherwise.
REQ-021 SHALL, in RUN, apply one +1 or -1 step to the working exponent per clock edge and decrement the remaining count.
REQ-022 SHALL, for an increment, set ovf and go to DONE on the edge where the result becomes all-ones, discarding the remaining steps.
REQ-023 SHALL, for an increment attempted at all-ones, hold all-ones, set ovf and go to DONE.
REQ-024 SHALL, for a decrement attempted at 0, hold 0, set unf and go to DONE; reaching 0 exactly is not underflow.
REQ-025 SHALL go from RUN to DONE on the edge where the remaining count reaches 0.
REQ-026 SHALL hold out_valid high in DONE, with exp_out, ovf and unf stable until out_ready is high.
REQ-027 SHALL return to IDLE on the edge where out_valid and out_ready are both high; in_valid is ignored outside IDLE (no overlap).
REQ-028 SHALL give latency as follows: out_valid is first high in the cycle after the k-th edge following accept, where k = steps performed (k = 0 for amount 0).
REQ-029 SHALL keep all arithmetic modulo-free: exp_out is never wrapped and always stays in 0..2^EXP_W-1.

Reset
REQ-030 SHALL, while reset is high at an edge, set state IDLE, in_ready=1, out_valid=0, busy=0, exp_out=0, ovf=0, unf=0 and counter=0.
REQ-031 SHALL, when reset is asserted mid-RUN or in DONE, discard the pending result without producing out_valid.

Configuration
REQ-032 SHALL, when macro EXP_ADJ_FAST_EN is defined, compute the saturated result and flags in one step at accept and enter DONE directly, so that k = 0 for every amount.
REQ-033 SHALL produce, in fast mode, exp_out, ovf and unf identical to the iterative mode for every input.
REQ-034 SHALL, without EXP_ADJ_FAST_EN, use the iterative RUN behaviour of REQ-021..REQ-025.

Verification
REQ-035 SHALL cover: exp_in=15, inc, amount=3 -> exp_out=18, ovf=0, unf=0, out_valid after 3 edges (fast mode: 0).
REQ-036 SHALL cover: exp_in=29, inc, amount=5 -> exp_out=31, ovf=1, DONE after 2 edges; exp_in=31, inc, amount=1 -> 31, ovf=1.
REQ-037 SHALL cover: exp_in=2, dec, amount=4 -> exp_out=0, unf=1 after 3 edges; exp_in=2, dec, amount=2 -> 0, unf=0.
REQ-038 SHALL cover: amount=0, exp_in=7 -> exp_out=7, out_valid in the cycle after accept, flags 0.
REQ-039 SHALL cover: out_ready held low for 5 cycles -> outputs stable and in_ready=0; a second in_valid during this time is not accepted.
REQ-040 SHALL cover: reset pulsed during RUN (exp_in=10, inc, amount=8) -> IDLE next cycle, out_valid never asserted, all outputs 0.
